data_mem_ctrl: RTL and testbench

//  Data-side memory access controller between the multicycle control FSM and the data memory port.

---
 rtl/data_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-side load/store controller: turns one start pulse into one handshaked memory
// transaction, handles sub-word alignment and extension, and flags misaligned accesses.
module data_mem_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            arstn,
  input  logic            i_start,
  input  logic            i_store,
  input  logic [2:0]      i_func_3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_stall,
  output logic            o_load_ma,
  output logic            o_store_ma,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [7:0]      o_mem_wstrb,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_off;
  logic [1:0]      r_size;
  logic            r_uns;
  logic            r_load_ma, r_store_ma;
  logic            r_mem_req, r_mem_we;
  logic [XLEN-1:0] r_mem_addr, r_mem_wdata, r_rdata;
  logic [7:0]      r_mem_wstrb;

  logic            w_ma, w_accept, w_reject, w_sx;
  logic [7:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata, w_shifted, w_ext;

  always_comb begin
    w_ma    = 1'b0;
    w_wstrb = 8'h01;
    case (i_func_3[1:0])
      2'b01:   begin w_ma = i_addr[0];      w_wstrb = 8'h03; end
      2'b10:   begin w_ma = |i_addr[1:0];   w_wstrb = 8'h0F; end
      2'b11:   begin w_ma = |i_addr[2:0];   w_wstrb = 8'hFF; end
      default: begin w_ma = 1'b0;           w_wstrb = 8'h01; end
    endcase
    w_wstrb = w_wstrb << i_addr[2:0];
  end

  assign w_wdata  = i_wdata << {i_addr[2:0], 3'b000};
  assign w_accept = (r_state == S_IDLE) && i_start && !w_ma;
  assign w_reject = (r_state == S_IDLE) && i_start && w_ma;

  // Load path: bring the addressed byte lane down to bit 0, then extend by size.
  assign w_shifted = i_mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_sx  = 1'b0;
    w_ext = w_shifted;
    case (r_size)
      2'b00: begin
        w_sx  = !r_uns && w_shifted[7];
        w_ext = {{(XLEN-8){w_sx}}, w_shifted[7:0]};
      end
      2'b01: begin
        w_sx  = !r_uns && w_shifted[15];
        w_ext = {{(XLEN-16){w_sx}}, w_shifted[15:0]};
      end
      2'b10: begin
        w_sx  = !r_uns && w_shifted[31];
        w_ext = {{(XLEN-32){w_sx}}, w_shifted[31:0]};
      end
      default: begin
        w_sx  = 1'b0;
        w_ext = w_shifted;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state     <= S_IDLE;
      r_off       <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_load_ma   <= 1'b0;
      r_store_ma  <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_reject) begin
            r_load_ma  <= r_load_ma  | !i_store;
            r_store_ma <= r_store_ma |  i_store;
          end else if (w_accept) begin
            r_off       <= i_addr[2:0];
            r_size      <= i_func_3[1:0];
            r_uns       <= i_func_3[2];
            r_load_ma   <= 1'b0;
            r_store_ma  <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_store;
            r_mem_addr  <= {i_addr[XLEN-1:3], 3'b000};
            r_mem_wdata <= w_wdata;
            r_mem_wstrb <= i_store ? w_wstrb : 8'h00;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_mem_ack) begin
            if (!r_mem_we) r_rdata <= w_ext;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          // Wait for the control FSM to drop start so one request never issues twice.
          if (!i_start) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_stall     = w_accept || (r_state == S_REQ);
  assign o_load_ma   = r_load_ma  || (w_reject && !i_store);
  assign o_store_ma  = r_store_ma || (w_reject &&  i_store);
  assign o_rdata     = r_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: driver pushes expected results, a monitor
// pops and compares whenever the DUT presents a start response or memory handshake.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        i_start = 1'b0, i_store = 1'b0;
  logic [2:0]  i_func_3 = '0;
  logic [63:0] i_addr = '0, i_wdata = '0;
  logic        o_stall, o_load_ma, o_store_ma, o_mem_req, o_mem_we;
  logic [63:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wstrb;
  logic        i_mem_ack = 1'b0;
  logic [63:0] i_mem_rdata = '0;

  data_mem_ctrl #(.XLEN(64)) dut (
    .clk(clk), .arstn(arstn), .i_start(i_start), .i_store(i_store),
    .i_func_3(i_func_3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_load_ma(o_load_ma), .o_store_ma(o_store_ma),
    .o_rdata(o_rdata), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { bit ma; bit ld_ma; bit st_ma; int stall; } iss_t;
  typedef struct { bit we; logic [63:0] addr; logic [63:0] wdata; logic [63:0] rdata; logic [7:0] wstrb; } mem_t;

  iss_t iss_q[$];
  mem_t mem_q[$];
  int   dly_q[$];
  int   stall_q[$];
  bit [63:0] mem [bit [63:0]];

  int n_chk = 0, n_pass = 0;
  logic [63:0] m_rdata = '0;
  bit m_sl = 0, m_ss = 0;
  bit mon_en = 0, resp_en = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Memory responder: acks each request after the delay the driver queued for it.
  initial begin
    bit active = 0;
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      i_mem_ack = 1'b0;
      if (!resp_en) active = 0;
      else if (o_mem_req) begin
        if (!active) begin
          active = 1;
          cnt = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
        end
        if (cnt == 0) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = mem.exists(o_mem_addr) ? mem[o_mem_addr] : 64'h0;
          active = 0;
        end else cnt--;
      end
    end
  end

  // Monitor
  initial begin
    bit p_start = 0, p_req = 0, rd_pend = 0;
    int scnt = 0;
    logic [63:0] rd_exp = '0;
    iss_t it;
    mem_t mt;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        p_start = 0; p_req = 0; rd_pend = 0; scnt = 0;
      end else begin
        if (i_start && !p_start) begin
          if (iss_q.size() == 0) chk("iss_q_empty", 1, 0);
          else begin
            it = iss_q.pop_front();
            chk("start_stall", o_stall, !it.ma);
            if (it.ma) begin
              chk("load_ma", o_load_ma, it.ld_ma);
              chk("store_ma", o_store_ma, it.st_ma);
              chk("ma_no_req", o_mem_req, 0);
            end else stall_q.push_back(it.stall);
          end
        end
        if (o_stall) scnt++;
        else if (scnt > 0) begin
          chk("stall_cycles", scnt, (stall_q.size() != 0) ? stall_q.pop_front() : -1);
          scnt = 0;
        end
        if (o_mem_req && !p_req) chk("req_expected", mem_q.size() != 0, 1);
        if (o_mem_req && mem_q.size() != 0) chk("addr_stable", o_mem_addr, mem_q[0].addr);
        if (rd_pend) begin
          chk("rdata", o_rdata, rd_exp);
          rd_pend = 0;
        end
        if (o_mem_req && i_mem_ack && mem_q.size() != 0) begin
          mt = mem_q.pop_front();
          chk("mem_we", o_mem_we, mt.we);
          chk("mem_wstrb", o_mem_wstrb, mt.wstrb);
          if (mt.we) chk("mem_wdata", o_mem_wdata, mt.wdata);
          rd_exp = mt.rdata;
          rd_pend = 1;
        end
        if (!i_start && !o_stall && !o_mem_req) begin
          chk("sticky_load_ma", o_load_ma, m_sl);
          chk("sticky_store_ma", o_store_ma, m_ss);
        end
        p_start = i_start;
        p_req = o_mem_req;
      end
    end
  end

  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] line,
                        input int dly, input int hold, input bit drop);
    int n, off;
    bit ma, done;
    logic [63:0] v, wexp;
    logic [7:0]  s;
    iss_t it;
    mem_t mt;
    n   = 1 << f3[1:0];
    off = int'(a % 8);
    ma  = (a % n) != 0;
    @(posedge clk); #1;
    i_start = 1'b1; i_store = st; i_func_3 = f3; i_addr = a; i_wdata = wd;
    if (ma) begin
      m_sl = m_sl | !st;
      m_ss = m_ss | st;
    end else begin
      m_sl = 0; m_ss = 0;
    end
    it.ma = ma; it.ld_ma = m_sl; it.st_ma = m_ss; it.stall = dly + 2;
    iss_q.push_back(it);
    if (!ma) begin
      v = '0; s = '0;
      if (!st) begin
        mem[{a[63:3], 3'b000}] = line;
        for (int k = 0; k < n; k++) v[8*k +: 8] = line[8*(off+k) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1])
          for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
        m_rdata = v;
      end else
        for (int k = 0; k < n; k++) s[off+k] = 1'b1;
      wexp = wd << (8*off);
      mt.we = st; mt.addr = {a[63:3], 3'b000}; mt.wdata = wexp; mt.rdata = m_rdata; mt.wstrb = s;
      dly_q.push_back(dly);
      mem_q.push_back(mt);
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(posedge clk); #1;
        if (drop && c == 0) i_start = 1'b0;
        if (!o_stall) done = 1;
      end
      if (!done) chk("stall_timeout", 0, 1);
      for (int h = 0; h < hold; h++) begin @(posedge clk); #1; end
    end else begin
      @(posedge clk); #1;
    end
    i_start = 1'b0;
  endtask

  task automatic rand_txn();
    bit st;
    logic [2:0] f3;
    logic [63:0] a;
    int n;
    st = ($urandom_range(0, 9) < 4);
    f3 = 3'($urandom_range(0, 7));
    if (st) f3[2] = 1'b0;
    n = 1 << f3[1:0];
    a = {32'($urandom), 32'($urandom)};
    if ($urandom_range(0, 9) < 7) a = a & ~64'(n - 1);
    do_txn(st, f3, a, {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
           $urandom_range(0, 4), $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_stall", o_stall, 0);
    chk("rst_req", o_mem_req, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_ma", {o_load_ma, o_store_ma}, 0);
    chk("rst_mem", {o_mem_we, o_mem_wstrb, o_mem_addr, o_mem_wdata}, 0);
    @(posedge clk); #1;
    arstn = 1'b1;
    mon_en = 1;
    do_txn(0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0);
    do_txn(1, 3'b001, 64'h2006, 64'hBEEF, 64'h0, 0, 0, 0);
    do_txn(0, 3'b010, 64'h2002, 64'h0, 64'h0, 0, 0, 0);
    do_txn(0, 3'b011, 64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF, 5, 3, 0);
    do_txn(0, 3'b110, 64'h4004, 64'h0, 64'h8000_0001_DEAD_BEEF, 0, 0, 0);
    do_txn(1, 3'b011, 64'h5003, 64'h1, 64'h0, 0, 0, 0);
    do_txn(0, 3'b001, 64'h6002, 64'h0, 64'h0000_0000_8001_0000, 3, 0, 1);
    for (int t = 0; t < 150; t++) rand_txn();

    // Reset while a load waits in REQ; a late ack must not leak through.
    @(posedge clk); #1;
    mon_en = 0; resp_en = 0;
    i_start = 1'b1; i_store = 1'b0; i_func_3 = 3'b011; i_addr = 64'h7000;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_mid_req", o_mem_req, 1);
    i_start = 1'b0;
    arstn = 1'b0;
    #1;
    chk("rst_mid_outs", {o_stall, o_mem_req, o_mem_we, o_load_ma, o_store_ma, o_mem_wstrb}, 0);
    chk("rst_mid_rdata", o_rdata, 0);
    chk("rst_mid_addr", o_mem_addr, 0);
    @(posedge clk); #1;
    arstn = 1'b1;
    i_mem_ack = 1'b1; i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    i_mem_ack = 1'b0;
    chk("late_ack_rdata", o_rdata, 0);
    chk("late_ack_req", {o_mem_req, o_stall}, 0);
    iss_q.delete(); mem_q.delete(); dly_q.delete(); stall_q.delete();
    m_rdata = '0; m_sl = 0; m_ss = 0;
    resp_en = 1;
    @(posedge clk); #1;
    mon_en = 1;
    do_txn(0, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 0, 0);
    for (int t = 0; t < 30; t++) rand_txn();
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
